// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer between the codec sample stream and a streaming FFT core:
// fills one bank while the other is burst to the FFT, then re-times the returned bins.
module fft_frame_scheduler #(
   parameter int LOG2N = 10,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             fft_sink_valid,
   input  logic             fft_sink_ready,
   output logic             fft_sink_sop,
   output logic             fft_sink_eop,
   output logic [WIDTH-1:0] fft_sink_real,
   input  logic             fft_source_valid,
   input  logic             fft_source_sop,
   input  logic             fft_source_eop,
   input  logic [WIDTH-1:0] fft_source_real,
   input  logic [WIDTH-1:0] fft_source_imag,
   output logic             bin_valid,
   output logic [LOG2N-1:0] bin_index,
   output logic [WIDTH-1:0] bin_real,
   output logic [WIDTH-1:0] bin_imag,
   output logic             frame_done,
   output logic             overrun,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;

   localparam logic [1:0] F_IDLE = 2'd0;
   localparam logic [1:0] F_FEED = 2'd1;
   localparam logic [1:0] F_WAIT = 2'd2;

   // Sink handshake: a word transfers on a rising edge where fft_sink_valid and
   // fft_sink_ready are both high; once valid is raised, the word and its sop/eop
   // stay unchanged until that transfer happens.

   logic [WIDTH-1:0] mem [0:2*N-1];

   logic [1:0]       state_q, state_d;
   logic [LOG2N-1:0] wr_ptr_q, wr_ptr_d;
   logic             cap_bank_q, cap_bank_d;
   logic             feed_bank_q, feed_bank_d;
   logic [LOG2N-1:0] ld_ptr_q, ld_ptr_d;
   logic             loaded_q, loaded_d;
   logic             sink_valid_q, sink_valid_d;
   logic             sink_sop_q, sink_sop_d;
   logic             sink_eop_q, sink_eop_d;
   logic [WIDTH-1:0] sink_real_q, sink_real_d;
   logic             bin_valid_q, bin_valid_d;
   logic [LOG2N-1:0] bin_index_q, bin_index_d;
   logic [LOG2N-1:0] bin_ptr_q, bin_ptr_d;
   logic [WIDTH-1:0] bin_real_q, bin_real_d;
   logic [WIDTH-1:0] bin_imag_q, bin_imag_d;
   logic             frame_done_q, frame_done_d;
   logic             overrun_q, overrun_d;

   logic             cap_wr;
   logic             bank_full;
   logic             src_beat;
   logic             src_last;
   logic             feed_free;
   logic             swap;
   logic             sink_fire;
   logic             load;
   logic [LOG2N-1:0] beat_idx;
   logic [WIDTH-1:0] rd_word;

   assign cap_wr    = sample_valid & enable;
   assign bank_full = cap_wr & (wr_ptr_q == LAST);
   assign src_beat  = fft_source_valid & (state_q == F_WAIT);
   assign src_last  = src_beat & fft_source_eop;
   assign feed_free = (state_q == F_IDLE) | src_last;
   assign swap      = bank_full & feed_free;
   assign sink_fire = sink_valid_q & fft_sink_ready;
   // The output register refills whenever it is empty or being drained this cycle.
   assign load      = (state_q == F_FEED) & ~loaded_q & (~sink_valid_q | fft_sink_ready);
   assign beat_idx  = fft_source_sop ? '0 : bin_ptr_q;
   assign rd_word   = mem[{feed_bank_q, ld_ptr_q}];

   always_ff @(posedge clk) begin
      if (cap_wr) begin
         mem[{cap_bank_q, wr_ptr_q}] <= sample_in;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      cap_bank_d   = cap_bank_q;
      feed_bank_d  = feed_bank_q;
      ld_ptr_d     = ld_ptr_q;
      loaded_d     = loaded_q;
      sink_valid_d = sink_valid_q;
      sink_sop_d   = sink_sop_q;
      sink_eop_d   = sink_eop_q;
      sink_real_d  = sink_real_q;
      bin_valid_d  = src_beat;
      bin_index_d  = bin_index_q;
      bin_ptr_d    = bin_ptr_q;
      bin_real_d   = bin_real_q;
      bin_imag_d   = bin_imag_q;
      frame_done_d = src_last;
      overrun_d    = overrun_q;

      if (cap_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (bank_full & ~feed_free) begin
         overrun_d = 1'b1;
      end
      if (swap) begin
         feed_bank_d = cap_bank_q;
         cap_bank_d  = ~cap_bank_q;
         ld_ptr_d    = '0;
         loaded_d    = 1'b0;
      end

      if (load) begin
         sink_valid_d = 1'b1;
         sink_real_d  = rd_word;
         sink_sop_d   = (ld_ptr_q == '0);
         sink_eop_d   = (ld_ptr_q == LAST);
         ld_ptr_d     = ld_ptr_q + 1'b1;
         loaded_d     = (ld_ptr_q == LAST);
      end else if (sink_fire) begin
         sink_valid_d = 1'b0;
         sink_sop_d   = 1'b0;
         sink_eop_d   = 1'b0;
      end

      // An over-delivering core simply wraps the index; a fresh sop restarts it.
      if (src_beat) begin
         bin_index_d = beat_idx;
         bin_ptr_d   = src_last ? '0 : beat_idx + 1'b1;
         bin_real_d  = fft_source_real;
         bin_imag_d  = fft_source_imag;
      end

      case (state_q)
         F_IDLE: begin
            if (swap) state_d = F_FEED;
         end
         F_FEED: begin
            if (sink_fire & sink_eop_q) begin
               state_d   = F_WAIT;
               bin_ptr_d = '0;
            end
         end
         F_WAIT: begin
            if (src_last) state_d = swap ? F_FEED : F_IDLE;
         end
         default: state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= F_IDLE;
         wr_ptr_q     <= '0;
         cap_bank_q   <= 1'b0;
         feed_bank_q  <= 1'b0;
         ld_ptr_q     <= '0;
         loaded_q     <= 1'b0;
         sink_valid_q <= 1'b0;
         sink_sop_q   <= 1'b0;
         sink_eop_q   <= 1'b0;
         sink_real_q  <= '0;
         bin_valid_q  <= 1'b0;
         bin_index_q  <= '0;
         bin_ptr_q    <= '0;
         bin_real_q   <= '0;
         bin_imag_q   <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         cap_bank_q   <= cap_bank_d;
         feed_bank_q  <= feed_bank_d;
         ld_ptr_q     <= ld_ptr_d;
         loaded_q     <= loaded_d;
         sink_valid_q <= sink_valid_d;
         sink_sop_q   <= sink_sop_d;
         sink_eop_q   <= sink_eop_d;
         sink_real_q  <= sink_real_d;
         bin_valid_q  <= bin_valid_d;
         bin_index_q  <= bin_index_d;
         bin_ptr_q    <= bin_ptr_d;
         bin_real_q   <= bin_real_d;
         bin_imag_q   <= bin_imag_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign fft_sink_valid = sink_valid_q;
   assign fft_sink_sop   = sink_sop_q;
   assign fft_sink_eop   = sink_eop_q;
   assign fft_sink_real  = sink_real_q;
   assign bin_valid      = bin_valid_q;
   assign bin_index      = bin_index_q;
   assign bin_real       = bin_real_q;
   assign bin_imag       = bin_imag_q;
   assign frame_done     = frame_done_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q != F_IDLE);
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler at N = 8: frame feed, handshake stalls,
// bin re-timing, overrun, enable pause and asynchronous reset mid-feed.
module tb_fft_frame_scheduler;

   localparam int LOG2N = 3;
   localparam int W     = 18;
   localparam int N     = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [W-1:0]     sample_in;
   logic             sample_valid;
   logic             fft_sink_valid;
   logic             fft_sink_ready;
   logic             fft_sink_sop;
   logic             fft_sink_eop;
   logic [W-1:0]     fft_sink_real;
   logic             fft_source_valid;
   logic             fft_source_sop;
   logic             fft_source_eop;
   logic [W-1:0]     fft_source_real;
   logic [W-1:0]     fft_source_imag;
   logic             bin_valid;
   logic [LOG2N-1:0] bin_index;
   logic [W-1:0]     bin_real;
   logic [W-1:0]     bin_imag;
   logic             frame_done;
   logic             overrun;
   logic             busy;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit reported = 1'b0;

   typedef struct {
      logic             src_valid;
      logic             src_sop;
      logic             src_eop;
      logic [W-1:0]     src_real;
      logic [W-1:0]     src_imag;
      logic             exp_valid;
      logic [LOG2N-1:0] exp_index;
      logic [W-1:0]     exp_real;
      logic [W-1:0]     exp_imag;
      logic             exp_done;
   } bin_vec_t;

   bin_vec_t bin_tab[10];

   fft_frame_scheduler #(.LOG2N(LOG2N), .WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .sample_in        (sample_in),
      .sample_valid     (sample_valid),
      .fft_sink_valid   (fft_sink_valid),
      .fft_sink_ready   (fft_sink_ready),
      .fft_sink_sop     (fft_sink_sop),
      .fft_sink_eop     (fft_sink_eop),
      .fft_sink_real    (fft_sink_real),
      .fft_source_valid (fft_source_valid),
      .fft_source_sop   (fft_source_sop),
      .fft_source_eop   (fft_source_eop),
      .fft_source_real  (fft_source_real),
      .fft_source_imag  (fft_source_imag),
      .bin_valid        (bin_valid),
      .bin_index        (bin_index),
      .bin_real         (bin_real),
      .bin_imag         (bin_imag),
      .frame_done       (frame_done),
      .overrun          (overrun),
      .busy             (busy),
      .dbg_state        (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report();
      if (!reported) begin
         reported = 1'b1;
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sink_valid"}, 32'(fft_sink_valid), 0);
      check({tag, "_sink_sop"},   32'(fft_sink_sop), 0);
      check({tag, "_sink_eop"},   32'(fft_sink_eop), 0);
      check({tag, "_sink_real"},  32'(fft_sink_real), 0);
      check({tag, "_bin_valid"},  32'(bin_valid), 0);
      check({tag, "_bin_index"},  32'(bin_index), 0);
      check({tag, "_bin_real"},   32'(bin_real), 0);
      check({tag, "_bin_imag"},   32'(bin_imag), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_overrun"},    32'(overrun), 0);
      check({tag, "_busy"},       32'(busy), 0);
      check({tag, "_state"},      32'(dbg_state), 0);
   endtask

   // Strobes count samples base, base+1, ... with gap idle cycles between strobes.
   task automatic send_samples(input int base, input int count, input int gap);
      for (int k = 0; k < count; k++) begin
         sample_in    = W'(base + k);
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
         if (k != count - 1) repeat (gap) tick();
      end
   endtask

   // Accepts one frame; mode 0 holds ready high, mode 1 toggles it every cycle.
   task automatic collect_frame(input string tag, input int base, input int mode, input int exp_first);
      int k     = 0;
      int cyc   = 0;
      int first = -1;
      int last  = 0;
      int lows  = 0;
      while (k < N && cyc < 200) begin
         fft_sink_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         if (fft_sink_valid) begin
            check({tag, "_word"}, 32'(fft_sink_real), 32'(W'(base + k)));
            check({tag, "_sop"},  32'(fft_sink_sop), 32'(k == 0));
            check({tag, "_eop"},  32'(fft_sink_eop), 32'(k == N - 1));
            if (first < 0) first = cyc;
            if (fft_sink_ready) begin
               k++;
               last = cyc;
            end else begin
               lows++;
            end
         end
         tick();
         cyc++;
      end
      fft_sink_ready = 1'b0;
      check({tag, "_beats"}, 32'(k), 32'(N));
      if (exp_first >= 0) check({tag, "_first_valid_cycle"}, 32'(first), 32'(exp_first));
      check({tag, "_feed_cycles"}, 32'(last - first + 1), 32'(N + lows));
      check({tag, "_valid_after_eop"}, 32'(fft_sink_valid), 0);
      check({tag, "_state_wait"}, 32'(dbg_state), 2);
   endtask

   // Returns bins from the FFT side; restart_at >= 0 inserts a second sop at that beat.
   task automatic drain_bins(input string tag, input int restart_at);
      int idx    = 0;
      int nbeats = (restart_at >= 0) ? N + restart_at : N;
      logic s_sop;
      logic s_eop;
      for (int b = 0; b < nbeats; b++) begin
         s_sop = (b == 0) || (b == restart_at);
         s_eop = (b == nbeats - 1);
         fft_source_valid = 1'b1;
         fft_source_sop   = s_sop;
         fft_source_eop   = s_eop;
         fft_source_real  = W'(100 + b);
         fft_source_imag  = W'(200 + b);
         tick();
         fft_source_valid = 1'b0;
         fft_source_sop   = 1'b0;
         fft_source_eop   = 1'b0;
         idx = s_sop ? 0 : idx + 1;
         check({tag, "_bin_valid"}, 32'(bin_valid), 1);
         check({tag, "_bin_index"}, 32'(bin_index), 32'(idx));
         check({tag, "_bin_real"},  32'(bin_real), 32'(W'(100 + b)));
         check({tag, "_frame_done"}, 32'(frame_done), 32'(s_eop));
      end
      check({tag, "_idle_after"}, 32'(busy), 0);
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      report();
      $finish;
   end

   initial begin
      for (int i = 0; i < 10; i++) begin
         int k;
         k = (i < 4) ? i : i - 1;
         bin_tab[i].src_valid = (i != 4) && (i != 9);
         bin_tab[i].src_sop   = (k == 0);
         bin_tab[i].src_eop   = (i == 8);
         bin_tab[i].src_real  = W'(k);
         bin_tab[i].src_imag  = W'(0 - k);
         bin_tab[i].exp_valid = (i != 4) && (i != 9);
         bin_tab[i].exp_index = LOG2N'(k);
         bin_tab[i].exp_real  = W'(k);
         bin_tab[i].exp_imag  = W'(0 - k);
         bin_tab[i].exp_done  = (i == 8);
      end

      reset = 1'b0;
      enable = 1'b0;
      sample_in = '0;
      sample_valid = 1'b0;
      fft_sink_ready = 1'b0;
      fft_source_valid = 1'b0;
      fft_source_sop = 1'b0;
      fft_source_eop = 1'b0;
      fft_source_real = '0;
      fft_source_imag = '0;
      #1;
      check_all_zero("reset_initial");
      tick();
      tick();
      check_all_zero("reset_held");
      reset = 1'b1;
      enable = 1'b1;
      tick();

      // Ramp frame with full-throughput feed and 2-cycle first-word latency.
      send_samples(0, N, 3);
      check("swap_busy", 32'(busy), 1);
      collect_frame("ramp", 0, 0, 1);

      // Table-driven loopback of bins, including an idle gap mid-frame.
      for (int i = 0; i < 10; i++) begin
         fft_source_valid = bin_tab[i].src_valid;
         fft_source_sop   = bin_tab[i].src_sop;
         fft_source_eop   = bin_tab[i].src_eop;
         fft_source_real  = bin_tab[i].src_real;
         fft_source_imag  = bin_tab[i].src_imag;
         tick();
         fft_source_valid = 1'b0;
         fft_source_sop   = 1'b0;
         fft_source_eop   = 1'b0;
         check($sformatf("bin_valid_%0d", i), 32'(bin_valid), 32'(bin_tab[i].exp_valid));
         check($sformatf("frame_done_%0d", i), 32'(frame_done), 32'(bin_tab[i].exp_done));
         if (bin_tab[i].exp_valid) begin
            check($sformatf("bin_index_%0d", i), 32'(bin_index), 32'(bin_tab[i].exp_index));
            check($sformatf("bin_real_%0d", i), 32'(bin_real), 32'(bin_tab[i].exp_real));
            check($sformatf("bin_imag_%0d", i), 32'(bin_imag), 32'(bin_tab[i].exp_imag));
         end
      end
      check("bins_idle_after", 32'(busy), 0);

      fft_source_valid = 1'b1;
      fft_source_sop   = 1'b1;
      fft_source_real  = W'(55);
      tick();
      fft_source_valid = 1'b0;
      fft_source_sop   = 1'b0;
      check("idle_beat_ignored", 32'(bin_valid), 0);
      check("idle_beat_no_done", 32'(frame_done), 0);

      // Stalling sink: ready toggles, words must hold while ready is low.
      send_samples(8, N, 1);
      collect_frame("toggle", 8, 1, 1);
      check("no_overrun_yet", 32'(overrun), 0);

      // Source held silent: a full frame arriving in F_WAIT is dropped.
      send_samples(16, N, 0);
      check("overrun_set", 32'(overrun), 1);
      check("overrun_no_feed_state", 32'(dbg_state), 2);
      tick();
      tick();
      check("overrun_no_sink_valid", 32'(fft_sink_valid), 0);
      drain_bins("drain_a", -1);
      send_samples(24, N, 3);
      collect_frame("after_overrun", 24, 0, 1);
      check("overrun_sticky", 32'(overrun), 1);
      drain_bins("restart", 3);

      // Enable dropped after 5 samples; strobes during the pause are ignored.
      send_samples(32, 5, 3);
      enable = 1'b0;
      sample_valid = 1'b1;
      sample_in = W'(18'h3ffff);
      repeat (20) tick();
      sample_valid = 1'b0;
      check("pause_idle", 32'(busy), 0);
      check("pause_no_sink", 32'(fft_sink_valid), 0);
      enable = 1'b1;
      tick();
      send_samples(37, 3, 3);
      collect_frame("paused", 32, 0, 1);
      drain_bins("drain_b", -1);

      // Asynchronous reset in the middle of a feed.
      send_samples(40, N, 1);
      fft_sink_ready = 1'b1;
      tick();
      tick();
      tick();
      check("mid_feed_valid", 32'(fft_sink_valid), 1);
      check("mid_feed_state", 32'(dbg_state), 1);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("reset_mid_feed");
      fft_sink_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_all_zero("after_reset");
      send_samples(50, N, 0);
      collect_frame("post_reset", 50, 0, 1);

      report();
      $finish;
   end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Frame scheduler between the codec sample stream and the streaming FFT core. It captures codec samples into a ping-pong frame buffer of 2^LOG2N words. Each time a bank fills, it hands that bank to the FFT as one framed burst with start-of-packet, end-of-packet and a valid/ready handshake. It then collects the returned bins and re-presents them with a bin index and an end-of-frame pulse for the pitch-detection logic downstream.

## Interface
- LOG2N, 10, log2 of frame length N (N = 1024 default)
- WIDTH, 18, sample and bin word width (matches codec sample width)
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- enable  in  1  capture enable; low = sample_valid ignored
- sample_in  in  WIDTH  codec sample, signed
- sample_valid  in  1  one-cycle strobe, sample_in valid
- fft_sink_valid  out  1  word presented to FFT
- fft_sink_ready  in  1  FFT accepts word when valid & ready
- fft_sink_sop  out  1  high with word index 0
- fft_sink_eop  out  1  high with word index N-1
- fft_sink_real  out  WIDTH  frame word (imag input tied 0 at top level)
- fft_source_valid  in  1  FFT output beat valid
- fft_source_sop / fft_source_eop  in  1 each  first / last output beat
- fft_source_real / fft_source_imag  in  WIDTH each  bin value
- bin_valid  out  1  bin output valid
- bin_index  out  LOG2N  bin number, 0 at source sop
- bin_real / bin_imag  out  WIDTH each  registered bin value
- frame_done  out  1  one-cycle pulse with last bin
- overrun  out  1  sticky: a full bank was dropped
- busy  out  1  feed FSM not in F_IDLE

## Operation
- Capture side: wr_ptr (LOG2N bits) and cap_bank select. Each accepted sample (sample_valid & enable) writes to cap_bank[wr_ptr], then wr_ptr increments.
- Bank full = accepted write at wr_ptr = N-1; wr_ptr wraps to 0.
  - Feed free: swap banks (feed bank <= cap_bank, cap_bank toggles) and start the feed FSM.
  - Feed not free: overrun <= 1, no swap. The same bank is overwritten from index 0 and the frame is discarded.
- Feed free = state F_IDLE, or F_WAIT with the final source beat (valid & eop) arriving this cycle.
- enable low mid-frame: wr_ptr held, partial frame kept, capture resumes on re-enable. A feed or drain already running completes.
- Feed FSM states:
  - F_IDLE: wait for swap → F_FEED.
  - F_FEED: present words rd_ptr 0..N-1. rd_ptr advances only on valid & ready. fft_sink_valid stays high and data stays stable while ready is low. eop beat accepted → F_WAIT.
  - F_WAIT: each source_valid beat → registered bin output. bin_index = 0 on sop and increments per beat; it wraps after N-1 if the core over-delivers. Beat with eop → frame_done, then → F_IDLE, or → F_FEED if a swap occurs in the same cycle.
- Source beats outside F_WAIT are ignored (no bin_valid).
- A source sop arriving mid-frame in F_WAIT restarts bin_index at 0.
- Reset: overrun clears only on reset.

## Timing
- Reset values: all outputs 0, wr_ptr = 0, cap_bank = 0, state F_IDLE.
- Swap at the edge after the filling write. fft_sink_valid with sop rises 2 cycles after the sample_valid cycle that wrote word N-1 (1 cycle swap + 1 cycle registered read).
- Full-throughput feed: N consecutive cycles with ready held high. Each ready-low cycle adds exactly 1 cycle.
- bin_valid / bin_index / bin_real / bin_imag: 1 cycle after the source beat. frame_done coincides with the last bin_valid.
- Sample rate ≪ clk rate is expected. Back-to-back sample_valid every cycle must still work: the capture and feed banks never alias.
- Reset asserted mid-feed: fft_sink_valid drops asynchronously and the frame is abandoned.

## Test plan
- LOG2N=3, ramp 0..7 via sample_valid every 4 cycles, ready=1 → sink words 0..7, sop with 0, eop with 7, first valid 2 cycles after 8th strobe.
- Same, ready toggling 1/0 → each word held stable while ready=0, 8 accepted beats total, rd order preserved.
- Loopback model returns 8 beats (real=k, imag=-k) → bin_index 0..7, values match, frame_done only with index 7, 1-cycle lag.
- Hold FFT source silent while second frame (8..15) fills → overrun=1, third frame (16..23) is the next fed frame, overrun stays 1 until reset.
- Stop enable after 5 samples for 20 cycles, resume → frame contains samples 0..7 contiguous, no gaps/duplicates.
- Assert reset (0) mid-F_FEED → all outputs 0 same cycle. After release, a fresh 8-sample frame feeds starting at sop, word 0.
